operand_scheduler: RTL and testbench

OPERAND_SCHEDULER -- requirements
Module: operand_scheduler

---
 rtl/operand_scheduler.sv | 146 ++++++++++++++
 tb/tb_operand_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/operand_scheduler.sv
// operand_scheduler
// Arbitrates two requesters onto one shared combinational datapath.
// Operands are registered onto dp_a/dp_b, the datapath result is sampled
// LATENCY edges later, and it is then held for the owning requester until
// that requester takes it. At most one transaction is in flight at a time.
module operand_scheduler #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_y,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    output logic [31:0] resp1_y,
    input  logic        resp1_ready,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    input  logic [31:0] dp_y,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Counter reload value: the result is sampled once the counter has
    // counted down from LATENCY-1 to zero, i.e. on the LATENCY-th edge.
    localparam logic [3:0] LAT_RELOAD = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_owner;
    logic        r_lastGrant;
    logic [31:0] r_result;
    logic [31:0] r_dpA;
    logic [31:0] r_dpB;
    logic        r_resp0Valid;
    logic        r_resp1Valid;
    logic        r_busy;

    logic w_grant0;
    logic w_grant1;
    logic w_accept0;
    logic w_accept1;
    logic w_ownerReady;

    // Round-robin grant: a sole valid requester wins; on a tie the
    // requester that was not served last wins. Re-evaluated every cycle.
    assign w_grant0 = req0_valid && (!req1_valid || r_lastGrant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_lastGrant);

    assign req0_ready = (r_state == IDLE) && w_grant0;
    assign req1_ready = (r_state == IDLE) && w_grant1;

    assign w_accept0 = req0_valid && req0_ready;
    assign w_accept1 = req1_valid && req1_ready;

    // Only the owner's response handshake can close a transaction.
    assign w_ownerReady = r_owner ? resp1_ready : resp0_ready;

    // Transaction sequencing: accept, wait out the datapath latency,
    // hold the response until the owner takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= 4'd0;
            r_owner      <= 1'b0;
            r_lastGrant  <= 1'b1;
            r_result     <= 32'd0;
            r_dpA        <= 32'd0;
            r_dpB        <= 32'd0;
            r_resp0Valid <= 1'b0;
            r_resp1Valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept0) begin
                        r_dpA   <= req0_a;
                        r_dpB   <= req0_b;
                        r_owner <= 1'b0;
                        r_count <= LAT_RELOAD;
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                    end else if (w_accept1) begin
                        r_dpA   <= req1_a;
                        r_dpB   <= req1_b;
                        r_owner <= 1'b1;
                        r_count <= LAT_RELOAD;
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_result <= dp_y;
                        r_state  <= RESP;
                        if (r_owner) begin
                            r_resp1Valid <= 1'b1;
                        end else begin
                            r_resp0Valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (w_ownerReady) begin
                        r_resp0Valid <= 1'b0;
                        r_resp1Valid <= 1'b0;
                        r_lastGrant  <= r_owner;
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp0Valid <= 1'b0;
                    r_resp1Valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Both response ports show the same result; valid marks the owner.
    assign resp0_valid = r_resp0Valid;
    assign resp1_valid = r_resp1Valid;
    assign resp0_y     = r_result;
    assign resp1_y     = r_result;
    assign dp_a        = r_dpA;
    assign dp_b        = r_dpB;
    assign busy        = r_busy;

endmodule

// File: tb/tb_operand_scheduler.sv
// tb_operand_scheduler
// Drives two scheduler instances (LATENCY 1 and 3) with the same requests
// and compares them every cycle against a transaction-level model.
// The shared datapath is modelled as dp_a + dp_b plus a per-cycle offset,
// so the result also reveals on which cycle dp_y was sampled.
module tb_operand_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_ready, resp1_ready;
    logic [31:0] noise [2];

    logic        wReady0 [2];
    logic        wReady1 [2];
    logic        wResp0Valid [2];
    logic        wResp1Valid [2];
    logic [31:0] wResp0Y [2];
    logic [31:0] wResp1Y [2];
    logic [31:0] wDpA [2];
    logic [31:0] wDpB [2];
    logic [31:0] wDpY [2];
    logic        wBusy [2];

    int lat [2] = '{1, 3};

    // Transaction-level reference state per instance
    bit          mBusy [2];
    bit          mOwner [2];
    int          mT [2];
    bit          mLast [2];
    logic [31:0] mResult [2];
    logic [31:0] mDpA [2];
    logic [31:0] mDpB [2];

    int nVec  = 0;
    int nMiss = 0;

    // Free-running clock
    always #5 clk = ~clk;

    assign wDpY[0] = wDpA[0] + wDpB[0] + noise[0];
    assign wDpY[1] = wDpA[1] + wDpB[1] + noise[1];

    operand_scheduler #(.LATENCY(1)) dutLat1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(wReady0[0]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(wReady1[0]),
        .resp0_valid(wResp0Valid[0]), .resp0_y(wResp0Y[0]), .resp0_ready(resp0_ready),
        .resp1_valid(wResp1Valid[0]), .resp1_y(wResp1Y[0]), .resp1_ready(resp1_ready),
        .dp_a(wDpA[0]), .dp_b(wDpB[0]), .dp_y(wDpY[0]), .busy(wBusy[0])
    );

    operand_scheduler #(.LATENCY(3)) dutLat3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(wReady0[1]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(wReady1[1]),
        .resp0_valid(wResp0Valid[1]), .resp0_y(wResp0Y[1]), .resp0_ready(resp0_ready),
        .resp1_valid(wResp1Valid[1]), .resp1_y(wResp1Y[1]), .resp1_ready(resp1_ready),
        .dp_a(wDpA[1]), .dp_b(wDpB[1]), .dp_y(wDpY[1]), .busy(wBusy[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which requester the arbiter should pick this cycle, -1 for none
    function automatic int grantOf(input int k);
        if (req0_valid && req1_valid) return mLast[k] ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mBusy[k]   = 1'b0;
            mOwner[k]  = 1'b0;
            mT[k]      = 0;
            mLast[k]   = 1'b1;
            mResult[k] = 32'd0;
            mDpA[k]    = 32'd0;
            mDpB[k]    = 32'd0;
        end
    endtask

    task automatic compareAll(input string phase);
        int  g;
        bit  inResp;
        for (int k = 0; k < 2; k++) begin
            g      = grantOf(k);
            inResp = mBusy[k] && (mT[k] >= lat[k]);
            checkOutput($sformatf("%su%0d.req0_ready", phase, k), 32'(wReady0[k]), 32'(!mBusy[k] && g == 0));
            checkOutput($sformatf("%su%0d.req1_ready", phase, k), 32'(wReady1[k]), 32'(!mBusy[k] && g == 1));
            checkOutput($sformatf("%su%0d.resp0_valid", phase, k), 32'(wResp0Valid[k]), 32'(inResp && !mOwner[k]));
            checkOutput($sformatf("%su%0d.resp1_valid", phase, k), 32'(wResp1Valid[k]), 32'(inResp && mOwner[k]));
            checkOutput($sformatf("%su%0d.resp0_y", phase, k), wResp0Y[k], mResult[k]);
            checkOutput($sformatf("%su%0d.resp1_y", phase, k), wResp1Y[k], mResult[k]);
            checkOutput($sformatf("%su%0d.busy", phase, k), 32'(wBusy[k]), 32'(mBusy[k]));
            checkOutput($sformatf("%su%0d.dp_a", phase, k), wDpA[k], mDpA[k]);
            checkOutput($sformatf("%su%0d.dp_b", phase, k), wDpB[k], mDpB[k]);
        end
    endtask

    // Advance the reference by one rising edge using the current inputs
    task automatic modelStep();
        int g;
        for (int k = 0; k < 2; k++) begin
            g = grantOf(k);
            if (!mBusy[k]) begin
                if (g >= 0) begin
                    mBusy[k]  = 1'b1;
                    mOwner[k] = (g == 1);
                    mT[k]     = 0;
                    mDpA[k]   = (g == 1) ? req1_a : req0_a;
                    mDpB[k]   = (g == 1) ? req1_b : req0_b;
                end
            end else if (mT[k] < lat[k]) begin
                if (mT[k] == lat[k] - 1) mResult[k] = mDpA[k] + mDpB[k] + noise[k];
                mT[k]++;
            end else if (mOwner[k] ? resp1_ready : resp0_ready) begin
                mBusy[k] = 1'b0;
                mLast[k] = mOwner[k];
            end
        end
    endtask

    // One cycle: drive on the falling edge, check, optional async reset, step model
    task automatic applyStimulus(
        input bit v0, input logic [31:0] a0, input logic [31:0] b0,
        input bit v1, input logic [31:0] a1, input logic [31:0] b1,
        input bit rr0, input bit rr1,
        input logic [31:0] n0, input logic [31:0] n1, input bit doReset
    );
        @(negedge clk);
        req0_valid  = v0;  req0_a = a0; req0_b = b0;
        req1_valid  = v1;  req1_a = a1; req1_b = b1;
        resp0_ready = rr0; resp1_ready = rr1;
        noise[0]    = n0;  noise[1] = n1;
        #1;
        compareAll("");
        if (doReset) begin
            #1 rst = 1'b1;
            #1;
            modelReset();
            compareAll("rst:");
            #1 rst = 1'b0;
        end
        modelStep();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        noise[0] = '0; noise[1] = '0;
        repeat (2) @(negedge clk);
        #1;
        modelReset();
        compareAll("init:");
        rst = 1'b0;

        // Single req0 transaction with its result taken at once
        applyStimulus(1, 32'h00000001, 32'h00001000, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("anchor.resp0_valid", 32'(wResp0Valid[0]), 32'd1);
        checkOutput("anchor.resp0_y", wResp0Y[0], 32'h00001001);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

        // Both requesters valid continuously: grants must alternate
        repeat (24) applyStimulus(1, 32'h10000000, 32'h00000001, 1, 32'h00001000, 32'h10000000,
                                  1, 1, 0, 0, 0);

        // Stalled responses with the non-owner's ready toggling
        for (int i = 0; i < 24; i++)
            applyStimulus(1, 32'h10000000, 32'h00000001, 1, 32'h00001000, 32'h10000000,
                          i[0], (i % 6) == 5, $urandom, $urandom, 0);

        // Random traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom,
                          $urandom_range(0, 9) < 7, $urandom, $urandom,
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                          $urandom, $urandom, $urandom_range(0, 149) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
